wallace_multiplier: RTL and testbench

Unsigned 16×16-bit multiplier producing a 32-bit product through a Wallace-tree partial-product reduction. A final carry-propagate adder completes each product. The block is a fully pipelined datapath element with a fixed latency, accepting a new operand pair every clock. It sits in the arithmetic/execute path and has no handshake.

---
 rtl/wallace_mul_pkg.sv | 28 ++
 rtl/csa_3to2.sv | 14 +
 rtl/wallace_multiplier.sv | 118 +++++++++++
 tb/tb_wallace_multiplier.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/wallace_mul_pkg.sv
// Shared constants for the Wallace-tree multiplier.
// Define WALLACE_MUL_PIPE_EN to add a register between the reduction tree and the final adder.
package wallace_mul_pkg;

    localparam int MUL_IN_W  = 16;
    localparam int MUL_OUT_W = 32;

`ifdef WALLACE_MUL_PIPE_EN
    localparam int MUL_LATENCY = 3;
`else
    localparam int MUL_LATENCY = 2;
`endif

    // 16 -> 11 -> 8 -> 6 -> 4 -> 3 -> 2 rows
    localparam int N_LEVELS = 6;

    // Each level turns every complete group of three rows into a sum row and a carry row.
    // Leftover rows pass through unchanged.
    function automatic int rows_at(input int level);
        int n;
        n = MUL_IN_W;
        for (int l = 0; l < level; l++) begin
            n = (n / 3) * 2 + (n % 3);
        end
        return n;
    endfunction

endpackage

// File: rtl/csa_3to2.sv
// Bit-level 3:2 compressor (full adder).
// Tie cin to 0 to get a half adder.
module csa_3to2 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/wallace_multiplier.sv
// Pipelined unsigned 16x16 -> 32 multiplier built from a Wallace reduction tree and a carry-propagate adder.
// Optional macro WALLACE_MUL_PIPE_EN registers the two reduced rows, which adds one cycle of latency.
module wallace_multiplier
    import wallace_mul_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MUL_IN_W-1:0]  A,
    input  logic [MUL_IN_W-1:0]  B,
    output logic [MUL_OUT_W-1:0] C
);

    localparam int W = MUL_OUT_W;

    logic [MUL_IN_W-1:0] a_d, a_q;
    logic [MUL_IN_W-1:0] b_d, b_q;
    logic [W-1:0]        c_d, c_q;
    logic [W-1:0]        red_d [2];
    logic [W-1:0]        fin_a, fin_b;

    always_comb begin
        a_d = A;
        b_d = B;
    end

    // NOTE: state uses non-blocking assignments so every register sees pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            c_q <= c_d;
        end
    end

    // Each level holds its rows in its own array. Carries out of bit 31 are dropped, because the
    // true product always fits in 32 bits.
    for (genvar l = 0; l <= N_LEVELS; l++) begin : lvl_g
        localparam int N = rows_at(l);
        logic [W-1:0] r [N];

        if (l == 0) begin : pp_g
            for (genvar i = 0; i < N; i++) begin : row_g
                assign r[i] = W'({MUL_IN_W{b_q[i]}} & a_q) << i;
            end
        end else begin : csa_g
            localparam int NP = rows_at(l - 1);
            localparam int G  = NP / 3;
            logic unused_cout [G];

            for (genvar g = 0; g < G; g++) begin : grp_g
                assign r[2*g+1][0] = 1'b0;
                for (genvar k = 0; k < W; k++) begin : col_g
                    if (k < W - 1) begin : fa_g
                        csa_3to2 u_csa (
                            .a    (lvl_g[l-1].r[3*g][k]),
                            .b    (lvl_g[l-1].r[3*g+1][k]),
                            .cin  (lvl_g[l-1].r[3*g+2][k]),
                            .sum  (r[2*g][k]),
                            .cout (r[2*g+1][k+1])
                        );
                    end else begin : top_g
                        csa_3to2 u_csa (
                            .a    (lvl_g[l-1].r[3*g][k]),
                            .b    (lvl_g[l-1].r[3*g+1][k]),
                            .cin  (lvl_g[l-1].r[3*g+2][k]),
                            .sum  (r[2*g][k]),
                            .cout (unused_cout[g])
                        );
                    end
                end
            end

            for (genvar m = 0; m < NP - 3 * G; m++) begin : pass_g
                assign r[2*G+m] = lvl_g[l-1].r[3*G+m];
            end
        end
    end

    always_comb begin
        red_d[0] = lvl_g[N_LEVELS].r[0];
        red_d[1] = lvl_g[N_LEVELS].r[1];
    end

`ifdef WALLACE_MUL_PIPE_EN
    logic [W-1:0] red_q [2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red_q[0] <= '0;
            red_q[1] <= '0;
        end else begin
            red_q[0] <= red_d[0];
            red_q[1] <= red_d[1];
        end
    end

    always_comb begin
        fin_a = red_q[0];
        fin_b = red_q[1];
    end
`else
    always_comb begin
        fin_a = red_d[0];
        fin_b = red_d[1];
    end
`endif

    always_comb begin
        c_d = fin_a + fin_b;
    end

    assign C = c_q;

endmodule

// File: tb/tb_wallace_multiplier.sv
// Directed and back-to-back checks of wallace_multiplier against bench-computed products.
// Latency follows MUL_LATENCY, so the same bench covers both WALLACE_MUL_PIPE_EN builds.
module tb_wallace_multiplier;
    import wallace_mul_pkg::*;

    localparam int LAT   = MUL_LATENCY;
    localparam int N_B2B = 1000;

    logic        clk;
    logic        rst;
    logic [15:0] A;
    logic [15:0] B;
    logic [31:0] C;

    int checks;
    int errors;

    logic [15:0] av [N_B2B];
    logic [15:0] bv [N_B2B];

    wallace_multiplier dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .C   (C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive a pair, then wait the full latency and sample just after the edge.
    task automatic apply_pair(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        A = a;
        B = b;
        repeat (LAT) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        A   = 16'h1234;
        B   = 16'h5678;
        #1;
        checks++;
        if (C !== 32'h0) begin
            errors++;
            $display("FAIL reset_async: C=%h expected %h", C, 32'h0);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (C !== 32'h0) begin
            errors++;
            $display("FAIL reset_held: C=%h expected %h", C, 32'h0);
        end
        @(negedge clk);
        A   = 16'h0;
        B   = 16'h0;
        rst = 1'b0;
        repeat (LAT + 1) @(posedge clk);
    endtask

    task automatic test_basic();
        @(negedge clk);
        A = 16'd12;
        B = 16'd3;
        repeat (LAT - 1) @(posedge clk);
        #1;
        checks++;
        if (C !== 32'h0) begin
            errors++;
            $display("FAIL latency_early: C=%h expected %h", C, 32'h0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (C !== 32'd36) begin
            errors++;
            $display("FAIL basic_12x3: C=%h expected %h", C, 32'd36);
        end
        apply_pair(16'd34, 16'd11);
        checks++;
        if (C !== 32'd374) begin
            errors++;
            $display("FAIL basic_34x11: C=%h expected %h", C, 32'd374);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (C !== 32'd374) begin
                errors++;
                $display("FAIL hold_%0d: C=%h expected %h", i, C, 32'd374);
            end
        end
    endtask

    task automatic test_extremes();
        apply_pair(16'hFFFF, 16'hFFFF);
        checks++;
        if (C !== 32'hFFFE0001) begin
            errors++;
            $display("FAIL ext_max: C=%h expected %h", C, 32'hFFFE0001);
        end
        apply_pair(16'h0000, 16'hFFFF);
        checks++;
        if (C !== 32'h0) begin
            errors++;
            $display("FAIL ext_zero: C=%h expected %h", C, 32'h0);
        end
        apply_pair(16'h0001, 16'hABCD);
        checks++;
        if (C !== 32'h0000ABCD) begin
            errors++;
            $display("FAIL ext_one: C=%h expected %h", C, 32'h0000ABCD);
        end
        apply_pair(16'h8000, 16'h8000);
        checks++;
        if (C !== 32'h40000000) begin
            errors++;
            $display("FAIL ext_msb: C=%h expected %h", C, 32'h40000000);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_c;
        int          idx;
        int          b2b_errs;
        b2b_errs = 0;
        for (int i = 0; i < N_B2B; i++) begin
            av[i] = 16'($urandom);
            bv[i] = 16'($urandom);
        end
        av[0] = 16'hFFFF; bv[0] = 16'hFFFF;
        av[1] = 16'h0000; bv[1] = 16'hFFFF;
        av[2] = 16'hFFFF; bv[2] = 16'h0001;
        for (int cyc = 0; cyc < N_B2B + LAT - 1; cyc++) begin
            @(negedge clk);
            A = (cyc < N_B2B) ? av[cyc] : 16'h0;
            B = (cyc < N_B2B) ? bv[cyc] : 16'h0;
            @(posedge clk);
            #1;
            if (cyc >= LAT - 1) begin
                idx   = cyc - LAT + 1;
                exp_c = 32'(av[idx]) * 32'(bv[idx]);
                checks++;
                if (C !== exp_c) begin
                    errors++;
                    b2b_errs++;
                    if (b2b_errs <= 10)
                        $display("FAIL b2b_%0d: A=%h B=%h C=%h expected %h",
                                 idx, av[idx], bv[idx], C, exp_c);
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        A = 16'h00FF;
        B = 16'h0101;
        @(posedge clk);
        @(negedge clk);
        A = 16'h1111;
        B = 16'h0003;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (C !== 32'h0) begin
            errors++;
            $display("FAIL midop_async: C=%h expected %h", C, 32'h0);
        end
        A = 16'd7;
        B = 16'd9;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (C !== 32'h0) begin
            errors++;
            $display("FAIL midop_held: C=%h expected %h", C, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        #1;
        checks++;
        if (C !== 32'h0) begin
            errors++;
            $display("FAIL midop_flush: C=%h expected %h", C, 32'h0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (C !== 32'd63) begin
            errors++;
            $display("FAIL midop_first: C=%h expected %h", C, 32'd63);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_hold();
        test_extremes();
        test_back_to_back();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
